tile_fetch_seq: RTL
===================

# tile_fetch_seq

Draw-clock line fetch sequencer for the tile background path. On each synchronized line pulse it walks the tile map for the upcoming scanline and issues one fetch request per 8 output pixels: tile map coordinates, tile row/column and line-buffer x. It applies per-frame horizontal and vertical scroll. It sits between the line/frame CDC synchronizers and the tile map BRAM stage. It replaces the free-running address counters with a valid/ready-throttled FSM so downstream stages can stall.

## Interface
Parameters:
- CORDW, 11, screen coordinate width
- FETCHES, 65, fetch requests per line: 64 covering 512 px, plus 1 for fine scroll

Ports:
- clk_draw  in  1  draw clock
- rst_draw  in  1  reset; asynchronous, active-high
- line_start  in  1  one-cycle pulse, already synchronized to clk_draw
- frame_start  in  1  one-cycle pulse, already synchronized to clk_draw
- sy  in  CORDW  screen line to prepare; sampled only on line_start
- scroll_x  in  9  horizontal scroll in screen pixels; sampled only on frame_start
- scroll_y  in  9  vertical scroll in screen lines; sampled only on frame_start
- fetch_ready  in  1  downstream accepts the current request
- fetch_valid  out  1  request fields are valid
- tile_map_x  out  5  tile map column
- tile_map_y  out  5  tile map row
- tile_row  out  3  pixel row within the tile
- tile_col  out  1  half of the tile row (pixels 0-3 or 4-7)
- lb_x  out  12  line buffer x of the first doubled pixel, two's complement
- line_first  out  1  request is fetch 0 of the line; used as the downstream per-line reset
- busy  out  1  FSM in FETCH
- done  out  1  one-cycle pulse after the final fetch of a line is accepted
- overrun  out  1  one-cycle pulse when line_start aborts an unfinished line

## Operation
- FSM states: IDLE, FETCH.
- On reset:
  - state IDLE.
  - All outputs 0.
  - Scroll shadow registers 0.
- frame_start latches scroll_x and scroll_y into the shadow registers.
  - A line already in FETCH keeps its own per-line copy of the scroll values.
- line_start, from any state:
  - Computes ly = (sy[8:0] + scroll_y_shadow) mod 512, using 9-bit wrap.
  - Latches tile_map_y = ly[8:4] and tile_row = ly[3:1]; every tile row is doubled.
  - Latches sx_coarse = scroll_x_shadow[8:3] and sx_fine = scroll_x_shadow[2:0].
  - Clears the fetch index f to 0 and enters FETCH.
- frame_start and line_start in the same cycle: the new scroll values are used for that line (shadow bypass).
- In FETCH, for fetch index f:
  - c = (sx_coarse + f) mod 64, 6-bit wrap.
  - tile_map_x = c[5:1], tile_col = c[0].
  - lb_x = 8*f − sx_fine, 12-bit two's complement. Fetch 0 is negative when sx_fine ≠ 0; the downstream mask discards negative pixels.
  - line_first = (f == 0).
- fetch_valid is high throughout FETCH.
- Request fields are stable while fetch_valid && !fetch_ready.
- Handshake (fetch_valid && fetch_ready):
  - If f < FETCHES−1: f increments.
  - If f == FETCHES−1: go to IDLE, drop fetch_valid, pulse done.
- line_start while in FETCH:
  - Pulse overrun and restart with the new line.
  - The in-flight request is dropped even if fetch_ready was high that cycle; no done is issued for the aborted line.
- line_start in the same cycle as the final handshake: counts as a restart. Pulse overrun=0, done=0.
- Reset asserted mid-line: immediate return to IDLE; the line is abandoned.

## Timing
- Every output is registered.
- line_start at cycle t: fetch_valid=1, f=0, busy=1 at t+1.
- With fetch_ready held 1: one fetch per cycle at t+1..t+FETCHES.
- Done and idle: done=1, busy=0, fetch_valid=0 at t+FETCHES+1.
- Each fetch_ready=0 cycle extends the schedule by exactly one cycle.
- overrun pulses in the cycle after the aborting line_start, together with the f=0 request of the new line.

## Structure
- Shared package vdp_pkg holds:
  - FETCHES_PER_LINE, PIXELS_PER_FETCH=8 and MAP_W_LOG2=5.
  - Enum fetch_state_t {IDLE, FETCH}.
  - Packed struct tile_fetch_t {map_x, map_y, row, col, lb_x, first}, reused by the tile map stage.
- Single module, no sub-module. Address arithmetic is small enough to stay inline.

## Test plan
- Reset, no scroll, sy=37, fetch_ready=1:
  - Fetch 0: map_y=2, row=2, map_x=0, col=0, lb_x=0, line_first=1.
  - Fetch 64: map_x=0, col=0, lb_x=512.
  - done pulses 66 cycles after line_start.
- scroll_x=0x1FD, scroll_y=500 latched on frame_start, then line_start with sy=20:
  - ly=8, so map_y=0, row=4.
  - Fetch 0: c=63, map_x=31, col=1, lb_x=−5 (0xFFB).
  - Fetch 1: c=0, lb_x=3.
- fetch_ready low for 3 cycles during fetch 10: fields held constant; done is delayed exactly 3 cycles.
- line_start at fetch 30: overrun pulses once, next request is f=0 with the new sy, no done for the aborted line.
- frame_start with new scroll values during FETCH: the current line is unchanged; the next line uses the new scroll. frame_start coincident with line_start: the new scroll applies immediately.
- Async reset pulsed mid-line, not aligned to clk_draw: all outputs 0 at once; IDLE until the next line_start.

Source files
------------

// File: rtl/vdp_pkg.sv
`default_nettype none
// ============================================================================
// vdp_pkg : shared constants and request type for the tile background path
// Rev 1.0
// ============================================================================
package vdp_pkg;

  localparam int FETCHES_PER_LINE = 65;
  localparam int PIXELS_PER_FETCH = 8;
  localparam int MAP_W_LOG2       = 5;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [MAP_W_LOG2-1:0] map_x;
    logic [MAP_W_LOG2-1:0] map_y;
    logic [2:0]            row;
    logic                  col;
    logic [11:0]           lb_x;
    logic                  first;
  } tile_fetch_t;

endpackage
`default_nettype wire

// File: rtl/tile_fetch_seq.sv
`default_nettype none
// ============================================================================
// tile_fetch_seq : per-line tile map fetch sequencer with scroll and
//                  valid/ready throttling, clocked in the draw domain
// Rev 1.0
// ============================================================================
module tile_fetch_seq
  import vdp_pkg::*;
#(
  parameter int CORDW   = 11,
  parameter int FETCHES = FETCHES_PER_LINE
) (
  input  logic             clk_draw,
  input  logic             rst_draw,
  input  logic             line_start,
  input  logic             frame_start,
  input  logic [CORDW-1:0] sy,
  input  logic [8:0]       scroll_x,
  input  logic [8:0]       scroll_y,
  input  logic             fetch_ready,
  output logic             fetch_valid,
  output logic [4:0]       tile_map_x,
  output logic [4:0]       tile_map_y,
  output logic [2:0]       tile_row,
  output logic             tile_col,
  output logic [11:0]      lb_x,
  output logic             line_first,
  output logic             busy,
  output logic             done,
  output logic             overrun
);

  localparam int F_W = $clog2(FETCHES);

  fetch_state_t state_q, state_d;
  logic [F_W-1:0] f_q, f_d;
  logic [5:0]     sx_coarse_q, sx_coarse_d;
  logic [2:0]     sx_fine_q, sx_fine_d;
  logic [8:0]     scroll_x_sh_q, scroll_x_sh_d;
  logic [8:0]     scroll_y_sh_q, scroll_y_sh_d;
  tile_fetch_t    req_q, req_d;
  logic           done_q, done_d;
  logic           overrun_q, overrun_d;

  logic [8:0] eff_sx;
  logic [8:0] eff_sy;
  logic [8:0] ly;
  logic [5:0] c;
  logic       final_hs;

  always_comb begin
    state_d       = state_q;
    f_d           = f_q;
    sx_coarse_d   = sx_coarse_q;
    sx_fine_d     = sx_fine_q;
    scroll_x_sh_d = scroll_x_sh_q;
    scroll_y_sh_d = scroll_y_sh_q;
    req_d         = req_q;
    done_d        = 1'b0;
    overrun_d     = 1'b0;

    // A coincident frame_start bypasses the shadow so this line sees the new scroll
    eff_sx   = frame_start ? scroll_x : scroll_x_sh_q;
    eff_sy   = frame_start ? scroll_y : scroll_y_sh_q;
    ly       = sy[8:0] + eff_sy;
    final_hs = (state_q == FETCH) && fetch_ready && (f_q == F_W'(FETCHES - 1));

    if (frame_start) begin
      scroll_x_sh_d = scroll_x;
      scroll_y_sh_d = scroll_y;
    end

    if (line_start) begin
      state_d     = FETCH;
      f_d         = '0;
      sx_coarse_d = eff_sx[8:3];
      sx_fine_d   = eff_sx[2:0];
      req_d.map_y = ly[8:4];
      req_d.row   = ly[3:1];
      overrun_d   = (state_q == FETCH) && !final_hs;
    end else if ((state_q == FETCH) && fetch_ready) begin
      if (final_hs) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        f_d = f_q + F_W'(1);
      end
    end

    // Request fields are computed from the next index so every output is a flop
    c = sx_coarse_d + 6'(f_d);
    if (state_d == FETCH) begin
      req_d.map_x = c[5:1];
      req_d.col   = c[0];
      req_d.lb_x  = 12'(f_d) * 12'(PIXELS_PER_FETCH) - 12'(sx_fine_d);
      req_d.first = (f_d == '0);
    end
  end

  always_ff @(posedge clk_draw or posedge rst_draw) begin
    if (rst_draw) begin
      state_q       <= IDLE;
      f_q           <= '0;
      sx_coarse_q   <= '0;
      sx_fine_q     <= '0;
      scroll_x_sh_q <= '0;
      scroll_y_sh_q <= '0;
      req_q         <= '0;
      done_q        <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      f_q           <= f_d;
      sx_coarse_q   <= sx_coarse_d;
      sx_fine_q     <= sx_fine_d;
      scroll_x_sh_q <= scroll_x_sh_d;
      scroll_y_sh_q <= scroll_y_sh_d;
      req_q         <= req_d;
      done_q        <= done_d;
      overrun_q     <= overrun_d;
    end
  end

  assign fetch_valid = (state_q == FETCH);
  assign busy        = (state_q == FETCH);
  assign tile_map_x  = req_q.map_x;
  assign tile_map_y  = req_q.map_y;
  assign tile_row    = req_q.row;
  assign tile_col    = req_q.col;
  assign lb_x        = req_q.lb_x;
  assign line_first  = req_q.first;
  assign done        = done_q;
  assign overrun     = overrun_q;

  // Rows are doubled, so ly[0] and the upper screen-line bits never select anything
  logic unused_bits;
  if (CORDW > 9) begin : g_sy_hi
    assign unused_bits = ^{sy[CORDW-1:9], ly[0]};
  end else begin : g_sy_narrow
    assign unused_bits = ly[0];
  end

endmodule
`default_nettype wire
